// File: rtl/pyfive_gpio_pkg.sv
// Register map and shared constants for the pyfive GPIO block.
package pyfive_gpio_pkg;

  localparam int unsigned GPIO_DW = 16;

  localparam logic [7:0] GPIO_OUT      = 8'h00;
  localparam logic [7:0] GPIO_OEB      = 8'h04;
  localparam logic [7:0] GPIO_IN       = 8'h08;
  localparam logic [7:0] GPIO_IRQ_EN   = 8'h0C;
  localparam logic [7:0] GPIO_IRQ_STAT = 8'h10;
  localparam logic [7:0] GPIO_OUT_SET  = 8'h14;
  localparam logic [7:0] GPIO_OUT_CLR  = 8'h18;

endpackage

// File: rtl/pyfive_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs; synchronous active-low reset.
module pyfive_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pyfive_gpio_ctrl.sv
// Wishbone register block driving the user GPIO pads: output data, output enables,
// synchronised inputs and rising-edge interrupt flags.
module pyfive_gpio_ctrl
  import pyfive_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned NPINS     = 16,
  parameter logic [15:0] OEB_RESET = 16'hFFFF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o,
  input  logic [NPINS-1:0] gpio_in,
  output logic [NPINS-1:0] gpio_out,
  output logic [NPINS-1:0] gpio_oeb,
  output logic             irq
);

  logic [NPINS-1:0] out_q, out_d;
  logic [NPINS-1:0] oeb_q, oeb_d;
  logic [NPINS-1:0] en_q, en_d;
  logic [NPINS-1:0] stat_q, stat_d;
  logic [NPINS-1:0] in_sync, in_dly_q, rise, w1c;
  logic [31:0]      dat_q, rdata;
  logic             ack_q, irq_q;
  logic             accept, wr;
  logic [7:0]       offset;
  logic [GPIO_DW-1:0] lane_mask;
  logic [NPINS-1:0] bmask, wdat;
  logic             unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  pyfive_sync2 #(
    .WIDTH(NPINS)
  ) u_sync (
    .clk_i (wb_clk_i),
    .rst_ni(wb_rst_n),
    .d_i   (gpio_in),
    .q_o   (in_sync)
  );

  // Blocking on ack_q spaces accepts so a held request acks every other cycle.
  assign accept = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr     = accept & wbs_we_i;
  assign offset = {wbs_adr_i[7:2], 2'b00};

  assign lane_mask = {{8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign bmask     = lane_mask[NPINS-1:0];
  assign wdat      = wbs_dat_i[NPINS-1:0] & bmask;
  assign rise      = in_sync & ~in_dly_q;

  always_comb begin
    out_d = out_q;
    oeb_d = oeb_q;
    en_d  = en_q;
    w1c   = '0;
    rdata = '0;
    case (offset)
      GPIO_OUT: begin
        rdata[NPINS-1:0] = out_q;
        if (wr) out_d = (out_q & ~bmask) | wdat;
      end
      GPIO_OEB: begin
        rdata[NPINS-1:0] = oeb_q;
        if (wr) oeb_d = (oeb_q & ~bmask) | wdat;
      end
      GPIO_IN: rdata[NPINS-1:0] = in_sync;
      GPIO_IRQ_EN: begin
        rdata[NPINS-1:0] = en_q;
        if (wr) en_d = (en_q & ~bmask) | wdat;
      end
      GPIO_IRQ_STAT: begin
        rdata[NPINS-1:0] = stat_q;
        if (wr) w1c = wdat;
      end
      GPIO_OUT_SET: if (wr) out_d = out_q | wdat;
      GPIO_OUT_CLR: if (wr) out_d = out_q & ~wdat;
      default: ;
    endcase
    // A new edge outranks a simultaneous clear.
    stat_d = (stat_q & ~w1c) | rise;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      out_q    <= '0;
      oeb_q    <= OEB_RESET[NPINS-1:0];
      en_q     <= '0;
      stat_q   <= '0;
      in_dly_q <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      oeb_q    <= oeb_d;
      en_q     <= en_d;
      stat_q   <= stat_d;
      in_dly_q <= in_sync;
      ack_q    <= accept;
      dat_q    <= accept ? rdata : '0;
      irq_q    <= |(stat_q & en_q);
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign gpio_out  = out_q;
  assign gpio_oeb  = oeb_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_pyfive_gpio_ctrl.sv
// Directed self-checking bench for pyfive_gpio_ctrl.
module tb_pyfive_gpio_ctrl;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, dat_o;
  logic        ack;
  logic [15:0] gin, gout, goeb;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        acked;
  int          nack;

  always #5 clk = ~clk;

  pyfive_gpio_ctrl dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_dat_o(dat_o),
    .wbs_ack_o(ack),
    .gpio_in  (gin),
    .gpio_out (gout),
    .gpio_oeb (goeb),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ack is seen, bus released.
  task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = Base | {24'h0, off}; wdat = d; sel = s;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin
        rd = dat_o; acked = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] off, input logic [31:0] d,
                    input logic [3:0] s);
    bus(1'b1, off, d, s);
    check({tag, " ack"}, {31'h0, acked}, 32'h1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    bus(1'b0, off, 32'h0, 4'hF);
    check({tag, " ack"}, {31'h0, acked}, 32'h1);
    check(tag, rd, exp);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; wdat = '0; gin = '0;
    repeat (3) @(negedge clk);
    check("rst oeb", {16'h0, goeb}, 32'hFFFF);
    check("rst irq", {31'h0, irq}, 32'h0);
    check("rst ack", {31'h0, ack}, 32'h0);
    check("rst out", {16'h0, gout}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("rd oeb", 8'h04, 32'h0000_FFFF);
    rd_chk("rd out", 8'h00, 32'h0);
    rd_chk("rd en", 8'h0C, 32'h0);
    rd_chk("rd stat", 8'h10, 32'h0);
    check("post oeb", {16'h0, goeb}, 32'hFFFF);
    check("post irq", {31'h0, irq}, 32'h0);

    // Basic output path
    wr("w out", 8'h00, 32'h0000_A5C3, 4'b0011);
    check("out a5c3", {16'h0, gout}, 32'hA5C3);
    wr("w oeb", 8'h04, 32'h0, 4'b0011);
    check("oeb 0", {16'h0, goeb}, 32'h0);
    wr("w set", 8'h14, 32'h0000_000C, 4'b0011);
    check("out set", {16'h0, gout}, 32'hA5CF);
    wr("w clr", 8'h18, 32'h0000_0081, 4'b0011);
    check("out clr", {16'h0, gout}, 32'hA54E);
    rd_chk("rd out2", 8'h00, 32'h0000_A54E);

    // Byte lanes
    wr("w out0", 8'h00, 32'h0, 4'b0011);
    wr("w lane1", 8'h00, 32'h0000_FFFF, 4'b0010);
    check("lane1", {16'h0, gout}, 32'hFF00);
    wr("w set lane0", 8'h14, 32'hFFFF_FFFF, 4'b0001);
    check("set lane0", {16'h0, gout}, 32'hFFFF);
    rd_chk("rd hole", 8'h40, 32'h0);
    check("dat idle", dat_o, 32'h0);

    // Out-of-window access
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base + 32'h100; nack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) nack++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("oow no ack", nack, 0);

    // Rising edge on pin 0 -> STAT[0] -> irq
    wr("w en0", 8'h0C, 32'h1, 4'b0011);
    @(negedge clk);
    gin[0] = 1'b1;
    @(negedge clk); check("irq t+1", {31'h0, irq}, 32'h0);
    @(negedge clk); check("irq t+2", {31'h0, irq}, 32'h0);
    @(negedge clk); check("irq t+3", {31'h0, irq}, 32'h0);
    @(negedge clk); check("irq t+4", {31'h0, irq}, 32'h1);
    rd_chk("rd stat0", 8'h10, 32'h1);
    wr("w1c 0", 8'h10, 32'h1, 4'b0011);
    check("irq at w1c ack", {31'h0, irq}, 32'h1);
    @(negedge clk); check("irq cleared", {31'h0, irq}, 32'h0);

    // IN latency on pin 1 (not enabled)
    gin[1] = 1'b1;
    rd_chk("in t+1", 8'h08, 32'h1);
    rd_chk("in t+3", 8'h08, 32'h3);
    rd_chk("stat1", 8'h10, 32'h2);
    check("irq masked", {31'h0, irq}, 32'h0);
    wr("w1c 1", 8'h10, 32'h2, 4'b0011);
    rd_chk("stat clr", 8'h10, 32'h0);

    // Set/clear collision on pin 3
    wr("w en3", 8'h0C, 32'h8, 4'b0011);
    gin[3] = 1'b1;
    repeat (5) @(negedge clk);
    check("irq pin3", {31'h0, irq}, 32'h1);
    gin[3] = 1'b0;
    repeat (4) @(negedge clk);
    gin[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr("w1c 3 coll", 8'h10, 32'h8, 4'b0011);
    @(negedge clk); check("irq coll", {31'h0, irq}, 32'h1);
    rd_chk("stat3 kept", 8'h10, 32'h8);
    wr("w1c 3", 8'h10, 32'h8, 4'b0011);
    @(negedge clk); check("irq off3", {31'h0, irq}, 32'h0);

    // Reset in the acceptance cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b0011;
    adr = Base; wdat = 32'h0000_1234; rst_n = 1'b0;
    @(negedge clk);
    check("rst ack drop", {31'h0, ack}, 32'h0);
    check("rst out0", {16'h0, gout}, 32'h0);
    check("rst oeb ff", {16'h0, goeb}, 32'hFFFF);
    we = 1'b0; rst_n = 1'b1;
    @(negedge clk); check("held ack1", {31'h0, ack}, 32'h1);
    check("held dat", dat_o, 32'h0);
    @(negedge clk); check("held ack2", {31'h0, ack}, 32'h0);
    @(negedge clk); check("held ack3", {31'h0, ack}, 32'h1);
    @(negedge clk); check("held ack4", {31'h0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pyfive_gpio_ctrl.md
Name: pyfive_gpio_ctrl

Overview:
- Wishbone-slave register block that configures and sequences the 16 user GPIO pads (io[26:11]) owned by pyfive_top.
- Holds output data, active-low output enables, synchronised input sampling and rising-edge interrupt flags.
- Instantiated inside pyfive_top on the Caravel WB slave bus, alongside the core's other slaves.
- Drives io_out/io_oeb and samples io_in for that pad range.

Parameters:
- BASE_ADDR, 32'h3000_0000, window base; decoded on wbs_adr_i[31:8].
- NPINS, 16, GPIO count; 1..16 supported, unused upper bits read 0.
- OEB_RESET, 16'hFFFF, reset value of OEB (all pads input).

Ports:
- wb_clk_i  in  1  system clock, all logic on rising edge
- wb_rst_n  in  1  synchronous active-low reset; the parent drives it as ~wb_rst_i
- wbs_cyc_i  in  1  WB cycle
- wbs_stb_i  in  1  WB strobe
- wbs_we_i  in  1  WB write enable
- wbs_sel_i  in  4  byte selects; only sel[1:0] are used
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data; zero whenever ack is low
- wbs_ack_o  out  1  single-cycle acknowledge
- gpio_in  in  NPINS  raw pad inputs (io_in[26:11])
- gpio_out  out  NPINS  pad output data
- gpio_oeb  out  NPINS  pad output enable, 0 = drive
- irq  out  1  level interrupt, OR of (STAT & EN)

Behaviour:
Register map (offset = adr[7:0]; adr[1:0] ignored):
- 0x00 OUT (RW)
- 0x04 OEB (RW)
- 0x08 IN (RO)
- 0x0C IRQ_EN (RW)
- 0x10 IRQ_STAT (W1C)
- 0x14 OUT_SET (WO, 1 sets the OUT bit)
- 0x18 OUT_CLR (WO, 1 clears the OUT bit)
- Other offsets in the window: acked, read 0, writes ignored.

Reset (wb_rst_n low at a clock edge):
- OUT=0, OEB=OEB_RESET, IRQ_EN=0, IRQ_STAT=0, sync flops=0.
- wbs_ack_o=0, wbs_dat_o=0, irq=0.
- Reset mid-transaction drops any pending ack; the master must retry.

Handshake:
- A request is accepted when cyc & stb & adr[31:8]==BASE_ADDR[31:8] & ~wbs_ack_o.
- wbs_ack_o rises the cycle after acceptance and holds for exactly 1 cycle.
- Held cyc/stb therefore yields ack every other cycle.
- Out-of-window requests are never acked.
- Write side effects commit on the same edge that raises ack.
- Read data is registered at acceptance and presented on wbs_dat_o only while ack is high.

Byte lanes:
- sel[0] gates bits [7:0]; sel[1] gates bits [15:8].
- Applies to all writable registers, including SET/CLR/W1C.
- Bits [31:16] read 0.

Input path:
- gpio_in passes through a 2-flop synchroniser to give IN; IN reflects a pad change 2 cycles later.
- Edge detect compares IN with a 1-cycle delayed copy.
- A rising edge sets STAT[i] on the 3rd edge after the pad change.

Interrupt:
- irq is registered: irq = |(IRQ_STAT & IRQ_EN), one cycle after either changes.

Boundary cases:
- Edge set and W1C clear of the same bit in the same cycle: set wins.
- OUT_SET and OUT_CLR are separate accesses, so they cannot collide.
- A write to OUT in the same cycle as any other OUT source is impossible (single port).
- Bits at or above NPINS are tied 0 in every register.

Decomposition:
- pyfive_gpio_pkg holds the register offset localparams (GPIO_OUT, GPIO_OEB, GPIO_IN, GPIO_IRQ_EN, GPIO_IRQ_STAT, GPIO_OUT_SET, GPIO_OUT_CLR) and the 16-bit data width constant.
- One sub-module, pyfive_sync2: a parameterised WIDTH-bit two-flop synchroniser with synchronous active-low reset. It is reused by other pad-facing blocks.

Test Plan:
- Reset check: release wb_rst_n, then read 0x04 -> 0x0000FFFF; reads of 0x00, 0x0C and 0x10 -> 0; irq=0 and gpio_oeb=16'hFFFF during reset and after.
- Write 0x00=0x0000A5C3 with sel=4'b0011, then write 0x04=0 -> gpio_out=16'hA5C3 and gpio_oeb=0 on the ack edge. Then OUT_SET 0x0000000C -> gpio_out=16'hA5CF; OUT_CLR 0x00000081 -> 16'hA54E.
- Byte lanes: write 0x00=0x0000FFFF with sel=4'b0010 starting from OUT=0 -> gpio_out=16'hFF00. Read of 0x40 -> ack with data 0. Access at BASE_ADDR+0x100 -> no ack for 10 cycles.
- Input edge: IRQ_EN=0x0001, drive gpio_in[0] 0->1 at cycle T -> read of 0x08 shows bit0=1 from T+2; STAT[0]=1 at T+3; irq=1 at T+4. W1C 0x10=1 -> irq=0 the cycle after ack.
- Collision: time the W1C of STAT[3] so it commits on the same edge as a new rising edge on pin 3 -> STAT[3] stays 1 and irq stays asserted.
- Reset mid-cycle: assert wb_rst_n=0 in the acceptance cycle of a write to 0x00 -> no ack and OUT=0. Held cyc/stb after reset -> ack pattern 0,1,0,1.
